bram_readback_checker: RTL and testbench



---
 rtl/bram_check_pkg.sv | 12 +
 rtl/check_delay_line.sv | 34 +++
 rtl/bram_readback_checker.sv | 147 ++++++++++++++
 tb/tb_bram_readback_checker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_check_pkg.sv
// Shared types for the BRAM readback checker: FSM state encoding.
package bram_check_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN  = 2'd0,
    ST_ERR  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/check_delay_line.sv
// Read-check pipeline: carries {valid, chk, expected, addr} for READ_LATENCY cycles
// so each entry lines up with the BRAM output word it describes.
module check_delay_line #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  push_valid,
  input  logic                  push_chk,
  input  logic                  push_expected,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  output logic                  tap_valid,
  output logic                  tap_chk,
  output logic                  tap_expected,
  output logic [ADDR_WIDTH-1:0] tap_addr
);

  localparam int unsigned ENTRY_W = ADDR_WIDTH + 3;

  logic [ENTRY_W-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= {push_valid, push_chk, push_expected, push_addr};
      for (int unsigned i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign {tap_valid, tap_chk, tap_expected, tap_addr} = stages[DEPTH-1];

endmodule

// File: rtl/bram_readback_checker.sv
// Snoops BRAM write/read ports, shadows one bit per word and checks every read
// word after the read latency; reports sticky error, saturating count, first address.
module bram_readback_checker
  import bram_check_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 36,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter bit          HALT_ON_ERR  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_bit,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  clr_errors,
  output logic                  err_flag,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  chk_pulse,
  output logic [STATE_W-1:0]    state
);

  localparam int unsigned WORDS = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WORDS-1:0] shadow_bits;
  logic [WORDS-1:0] valid_bits;

  // Shadow tracks writes in every state; only the valid vector needs reset
  always_ff @(posedge clk) begin
    if (wr_en) shadow_bits[wr_addr] <= wr_bit;
  end

  always_ff @(posedge clk) begin
    if (rst)        valid_bits <= '0;
    else if (wr_en) valid_bits[wr_addr] <= 1'b1;
  end

  // Cross-port read-during-write to one address is undefined, so skip it
  logic collide_c;
  logic push_chk_c;
  assign collide_c  = wr_en && (wr_addr == rd_addr);
  assign push_chk_c = valid_bits[rd_addr] && !collide_c;

  logic                  tap_valid;
  logic                  tap_chk;
  logic                  tap_expected;
  logic [ADDR_WIDTH-1:0] tap_addr;

  check_delay_line #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (READ_LATENCY)
  ) u_delay (
    .clk          (clk),
    .flush        (rst || clr_errors),
    .push_valid   (rd_en),
    .push_chk     (push_chk_c),
    .push_expected(shadow_bits[rd_addr]),
    .push_addr    (rd_addr),
    .tap_valid    (tap_valid),
    .tap_chk      (tap_chk),
    .tap_expected (tap_expected),
    .tap_addr     (tap_addr)
  );

  logic cmp_c;
  logic mismatch_c;
  assign cmp_c      = tap_valid && tap_chk;
  assign mismatch_c = cmp_c && (rd_data != {DATA_WIDTH{tap_expected}});

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_errors) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && mismatch_c) begin
      state_d = HALT_ON_ERR ? ST_HALT : ST_ERR;
    end
  end

  logic                  err_flag_d;
  logic [CNT_WIDTH-1:0]  err_count_d;
  logic [ADDR_WIDTH-1:0] first_err_addr_d;
  logic                  chk_pulse_d;
  logic [CNT_WIDTH-1:0]  cnt_inc_c;

  assign cnt_inc_c = (err_count == CNT_MAX) ? err_count : err_count + CNT_WIDTH'(1);

  // Next values of the registered status outputs; clear wins over a same-cycle mismatch
  always_comb begin
    err_flag_d       = err_flag;
    err_count_d      = err_count;
    first_err_addr_d = first_err_addr;
    chk_pulse_d      = 1'b0;
    if (clr_errors) begin
      err_flag_d       = 1'b0;
      err_count_d      = '0;
      first_err_addr_d = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mismatch_c) begin
            err_flag_d       = 1'b1;
            err_count_d      = cnt_inc_c;
            first_err_addr_d = tap_addr;
          end else if (cmp_c) begin
            chk_pulse_d = 1'b1;
          end
        end
        ST_ERR: begin
          if (mismatch_c)  err_count_d = cnt_inc_c;
          else if (cmp_c)  chk_pulse_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      chk_pulse      <= 1'b0;
    end else begin
      err_flag       <= err_flag_d;
      err_count      <= err_count_d;
      first_err_addr <= first_err_addr_d;
      chk_pulse      <= chk_pulse_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_bram_readback_checker.sv
// Directed bench for bram_readback_checker across halt, no-halt, narrow-counter
// and two-cycle-latency configurations driven from shared stimulus.
module tb_bram_readback_checker;

  localparam int unsigned DW = 36;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          wr_bit = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_errors = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] rd_data2 = '0;

  logic          a_flag, b_flag, c_flag, d_flag;
  logic [7:0]    a_cnt, b_cnt, d_cnt;
  logic [1:0]    c_cnt;
  logic [AW-1:0] a_first, b_first, c_first, d_first;
  logic          a_pulse, b_pulse, c_pulse, d_pulse;
  logic [1:0]    a_state, b_state, c_state, d_state;

  int tests = 0;
  int fails = 0;
  int pulses;
  int errs;

  always #5 clk = ~clk;

  bram_readback_checker u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_bit(wr_bit),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .clr_errors(clr_errors),
    .err_flag(a_flag), .err_count(a_cnt), .first_err_addr(a_first),
    .chk_pulse(a_pulse), .state(a_state)
  );

  bram_readback_checker #(.HALT_ON_ERR(1'b0)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_bit(wr_bit),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .clr_errors(clr_errors),
    .err_flag(b_flag), .err_count(b_cnt), .first_err_addr(b_first),
    .chk_pulse(b_pulse), .state(b_state)
  );

  bram_readback_checker #(.HALT_ON_ERR(1'b0), .CNT_WIDTH(2)) u_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_bit(wr_bit),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .clr_errors(clr_errors),
    .err_flag(c_flag), .err_count(c_cnt), .first_err_addr(c_first),
    .chk_pulse(c_pulse), .state(c_state)
  );

  bram_readback_checker #(.READ_LATENCY(2)) u_d (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_bit(wr_bit),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .clr_errors(clr_errors),
    .err_flag(d_flag), .err_count(d_cnt), .first_err_addr(d_first),
    .chk_pulse(d_pulse), .state(d_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic b);
    wr_en = 1'b1; wr_addr = a; wr_bit = b;
    tick();
    wr_en = 1'b0;
  endtask

  // Latency-1 read: issue, then present the BRAM word in the following cycle
  task automatic rd1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0; rd_data = d;
    tick();
    rd_data = '0;
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return {1'(i % 2), 9'(i)};
  endfunction

  function automatic logic bit_of(input int i);
    return 1'((i >> 1) & 1);
  endfunction

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_flag",  64'(a_flag),  64'd0);
    check("rst_cnt",   64'(a_cnt),   64'd0);
    check("rst_first", 64'(a_first), 64'd0);
    check("rst_pulse", 64'(a_pulse), 64'd0);
    check("rst_state", 64'(a_state), 64'd0);

    // Good read of a written word
    wr(10'h005, 1'b1);
    tick();
    rd1(10'h005, 36'hF_FFFF_FFFF);
    check("good_pulse", 64'(a_pulse), 64'd1);
    check("good_flag",  64'(a_flag),  64'd0);
    tick();
    check("good_pulse_once", 64'(a_pulse), 64'd0);

    // Never-written address is not checked
    rd1(10'h200, 36'h1_2345_6789);
    check("unwritten_pulse", 64'(a_pulse), 64'd0);
    check("unwritten_flag",  64'(a_flag),  64'd0);

    // Same-address read/write collision is skipped; the new bit lands in the shadow
    wr(10'h007, 1'b1);
    rd_en = 1'b1; rd_addr = 10'h007; wr_en = 1'b1; wr_addr = 10'h007; wr_bit = 1'b0;
    tick();
    rd_en = 1'b0; wr_en = 1'b0; rd_data = '0;
    tick();
    check("collide_pulse", 64'(a_pulse), 64'd0);
    check("collide_flag",  64'(a_flag),  64'd0);
    rd1(10'h007, 36'h0);
    check("after_collide_pulse", 64'(a_pulse), 64'd1);

    // Torn word triggers error and halt
    rd1(10'h005, 36'hF_FFFF_FFFE);
    check("torn_flag",  64'(a_flag),  64'd1);
    check("torn_cnt",   64'(a_cnt),   64'd1);
    check("torn_first", 64'(a_first), 64'h005);
    check("torn_state", 64'(a_state), 64'd2);
    check("torn_pulse", 64'(a_pulse), 64'd0);
    check("torn_b_state", 64'(b_state), 64'd1);
    rd1(10'h005, 36'h0);
    check("halt_cnt",   64'(a_cnt),   64'd1);
    check("halt_state", 64'(a_state), 64'd2);
    check("err_b_cnt",  64'(b_cnt),   64'd2);
    check("err_b_first", 64'(b_first), 64'h005);

    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_state", 64'(a_state), 64'd0);
    check("rst2_flag",  64'(a_flag),  64'd0);

    // Multiple mismatches without halting, plus counter saturation
    wr(10'h010, 1'b1);
    wr(10'h011, 1'b0);
    wr(10'h012, 1'b1);
    rd1(10'h010, 36'h0);
    rd1(10'h011, 36'hF_FFFF_FFFF);
    rd1(10'h012, 36'h0_0000_0001);
    check("noh_cnt",   64'(b_cnt),   64'd3);
    check("noh_first", 64'(b_first), 64'h010);
    check("noh_state", 64'(b_state), 64'd1);
    check("noh_flag",  64'(b_flag),  64'd1);
    check("halt_cnt2", 64'(a_cnt),   64'd1);
    check("halt_first2", 64'(a_first), 64'h010);
    rd1(10'h010, 36'h0);
    rd1(10'h010, 36'h0);
    check("noh_cnt5",  64'(b_cnt),   64'd5);
    check("sat_cnt",   64'(c_cnt),   64'd3);
    check("sat_state", 64'(c_state), 64'd1);

    // Clear on a mismatch cycle wins
    rd_en = 1'b1; rd_addr = 10'h010;
    tick();
    rd_en = 1'b0; rd_data = '0; clr_errors = 1'b1;
    tick();
    clr_errors = 1'b0;
    check("clr_flag",  64'(b_flag),  64'd0);
    check("clr_cnt",   64'(b_cnt),   64'd0);
    check("clr_first", 64'(b_first), 64'd0);
    check("clr_state", 64'(b_state), 64'd0);
    check("clr_a_state", 64'(a_state), 64'd0);
    check("clr_c_cnt", 64'(c_cnt),   64'd0);
    rd1(10'h010, 36'hF_FFFF_FFFF);
    check("clr_keep_shadow", 64'(a_pulse), 64'd1);

    // Latency 2: pipelined alternating-bank writes and reads
    rst = 1'b1; tick(); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_addr = addr_of(i); wr_bit = bit_of(i);
      rd_en = (i >= 2);
      rd_addr = (i >= 2) ? addr_of(i - 2) : '0;
      rd_data2 = (i >= 4) ? {DW{bit_of(i - 4)}} : '0;
      tick();
      if (d_pulse) pulses++;
    end
    check("lat2_pulses", 64'(pulses), 64'd6);
    check("lat2_cnt",    64'(d_cnt),  64'd0);
    check("lat2_flag",   64'(d_flag), 64'd0);

    // Reset mid-stream with reads in flight
    rst = 1'b1; wr_addr = addr_of(10); wr_bit = bit_of(10);
    rd_addr = addr_of(8); rd_data2 = {DW{bit_of(6)}};
    tick();
    rst = 1'b0; wr_en = 1'b0;
    check("lat2_rst_state", 64'(d_state), 64'd0);
    check("lat2_rst_cnt",   64'(d_cnt),   64'd0);
    pulses = 0; errs = 0;
    rd_data2 = 36'h5_A5A5_A5A5;
    for (int i = 11; i < 18; i++) begin
      rd_en = (i < 16);
      rd_addr = addr_of(i - 9);
      tick();
      if (d_pulse) pulses++;
      if (d_flag) errs++;
    end
    check("post_rst_pulses", 64'(pulses), 64'd0);
    check("post_rst_errs",   64'(errs),   64'd0);
    check("post_rst_cnt",    64'(d_cnt),  64'd0);

    wr(addr_of(3), 1'b1);
    rd_en = 1'b1; rd_addr = addr_of(3);
    tick();
    rd_en = 1'b0;
    tick();
    rd_data2 = '1;
    tick();
    check("rewrite_pulse", 64'(d_pulse), 64'd1);
    check("rewrite_flag",  64'(d_flag),  64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
